// File: rtl/dht11_scheduler_pkg.sv
// DHT11 scheduler shared types: FSM state encoding, data range limits
// and the 8-bit saturating increment used by the error counter.
package dht11_scheduler_pkg;

    typedef enum logic [2:0] {
        BOOT,
        IDLE,
        REQ,
        WAIT,
        HOLDOFF
    } state_t;

    localparam logic [7:0] RH_MAX = 8'd100;
    localparam logic [7:0] T_MAX  = 8'd60;
    localparam logic [7:0] SAT8   = 8'd255;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == SAT8) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dht11_sched_ms_tick.sv
// One-cycle 1 ms tick generator derived from the system clock rate.
// Counter and tick are cleared by a synchronous active-high reset.
module dht11_sched_ms_tick #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int unsigned DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int          W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] r_cnt;
    logic         r_tick;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + W'(1);
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/dht11_scheduler.sv
// DHT11 measurement scheduler: boot settle, periodic/manual starts, timeout,
// retry with holdoff and sticky fault. DHT11_SCHED_HYST_EN adds a fan output.
module dht11_scheduler
    import dht11_scheduler_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BOOT_MS    = 1000,
    parameter int unsigned PERIOD_MS  = 2000,
    parameter int unsigned TIMEOUT_MS = 30,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       trigger,
    output logic       sensor_start,
    input  logic       sensor_done,
    input  logic [7:0] sensor_rh,
    input  logic [7:0] sensor_t,
    output logic [7:0] rh_out,
    output logic [7:0] t_out,
    output logic       data_valid,
    output logic       busy,
    output logic       fault,
    output logic [7:0] err_cnt
`ifdef DHT11_SCHED_HYST_EN
    ,
    input  logic [7:0] t_on,
    input  logic [7:0] t_off,
    output logic       fan_on
`endif
);

    localparam logic [15:0] BOOT_LAST = 16'(BOOT_MS - 1);
    localparam logic [15:0] PERIOD    = 16'(PERIOD_MS);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_MS - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [15:0] r_to, w_to_nxt;
    logic [3:0]  r_retry, w_retry_nxt;
    logic        r_pend, w_pend_nxt;
    logic        r_valid, w_valid_nxt;
    logic [7:0]  r_rh, w_rh_nxt;
    logic [7:0]  r_t, w_t_nxt;
    logic        r_fault, w_fault_nxt;
    logic [7:0]  r_err, w_err_nxt;
    logic        w_tick;
    logic        w_accept;
    logic        w_fail;
    logic [3:0]  w_retry_inc;
`ifdef DHT11_SCHED_HYST_EN
    logic        r_fan, w_fan_nxt;
`endif

    dht11_sched_ms_tick #(
        .CLK_HZ (CLK_HZ)
    ) u_tick (
        .i_clk  (clk),
        .i_rst  (rst),
        .o_tick (w_tick)
    );

    assign w_retry_inc = r_retry + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_to_nxt    = r_to;
        w_retry_nxt = r_retry;
        w_pend_nxt  = r_pend;
        w_valid_nxt = 1'b0;
        w_rh_nxt    = r_rh;
        w_t_nxt     = r_t;
        w_fault_nxt = r_fault;
        w_err_nxt   = r_err;
        w_accept    = 1'b0;
        w_fail      = 1'b0;
`ifdef DHT11_SCHED_HYST_EN
        w_fan_nxt   = r_fan;
`endif
        if (trigger && !(r_state == IDLE && enable))
            w_pend_nxt = 1'b1;

        unique case (r_state)
            BOOT: if (w_tick) begin
                if (r_cnt == BOOT_LAST) begin
                    // first reading is due as soon as the sensor has settled
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = PERIOD;
                    w_pend_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            IDLE: begin
                if (w_tick && r_cnt != 16'd0)
                    w_cnt_nxt = r_cnt - 16'd1;
                if (enable && (r_pend || trigger || r_cnt == 16'd0 ||
                               (w_tick && r_cnt == 16'd1)))
                    w_state_nxt = REQ;
            end
            REQ: begin
                w_to_nxt    = 16'd0;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (sensor_done) begin
                    if (sensor_rh <= RH_MAX && sensor_t <= T_MAX)
                        w_accept = 1'b1;
                    else
                        w_fail = 1'b1;
                end else if (w_tick) begin
                    if (r_to == TO_LAST)
                        w_fail = 1'b1;
                    else
                        w_to_nxt = r_to + 16'd1;
                end
            end
            HOLDOFF: if (w_tick) begin
                if (r_cnt <= 16'd1) begin
                    if (enable) begin
                        w_state_nxt = REQ;
                    end else begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = PERIOD;
                        w_retry_nxt = 4'd0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            default: w_state_nxt = BOOT;
        endcase

        if (w_accept) begin
            w_rh_nxt    = sensor_rh;
            w_t_nxt     = sensor_t;
            w_valid_nxt = 1'b1;
            w_retry_nxt = 4'd0;
            w_fault_nxt = 1'b0;
            w_cnt_nxt   = PERIOD;
            w_state_nxt = IDLE;
`ifdef DHT11_SCHED_HYST_EN
            if (sensor_t >= t_on)
                w_fan_nxt = 1'b1;
            else if (sensor_t <= t_off)
                w_fan_nxt = 1'b0;
`endif
        end

        if (w_fail) begin
            w_err_nxt = sat_inc8(r_err);
            w_cnt_nxt = PERIOD;
            if (w_retry_inc > RETRY_MAX) begin
                w_fault_nxt = 1'b1;
                w_retry_nxt = 4'd0;
                w_state_nxt = IDLE;
            end else begin
                w_retry_nxt = w_retry_inc;
                w_state_nxt = HOLDOFF;
            end
        end

        if (w_state_nxt == REQ)
            w_pend_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BOOT;
            r_cnt   <= '0;
            r_to    <= '0;
            r_retry <= '0;
            r_pend  <= 1'b0;
            r_valid <= 1'b0;
            r_rh    <= '0;
            r_t     <= '0;
            r_fault <= 1'b0;
            r_err   <= '0;
`ifdef DHT11_SCHED_HYST_EN
            r_fan   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_to    <= w_to_nxt;
            r_retry <= w_retry_nxt;
            r_pend  <= w_pend_nxt;
            r_valid <= w_valid_nxt;
            r_rh    <= w_rh_nxt;
            r_t     <= w_t_nxt;
            r_fault <= w_fault_nxt;
            r_err   <= w_err_nxt;
`ifdef DHT11_SCHED_HYST_EN
            r_fan   <= w_fan_nxt;
`endif
        end
    end

    assign sensor_start = (r_state == REQ);
    assign busy         = (r_state != IDLE);
    assign data_valid   = r_valid;
    assign rh_out       = r_rh;
    assign t_out        = r_t;
    assign fault        = r_fault;
    assign err_cnt      = r_err;
`ifdef DHT11_SCHED_HYST_EN
    assign fan_on       = r_fan;
`endif

endmodule
